// File: rtl/kbd_event_fifo.sv
// Event buffer between the keyboard/mouse serial receiver and the host register interface.
// Fetches words with a retrieved strobe, queues them first-word-fall-through, and drops on prolonged full.
module kbd_event_fifo #(
    parameter int DEPTH       = 8,
    parameter int STALL_LIMIT = 4096,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       kb_data_ready,
    input  logic                       kb_is_mouse,
    input  logic [15:0]                kb_data,
    output logic                       kb_data_retrieved,
    output logic                       ev_valid,
    input  logic                       ev_ready,
    output logic                       ev_is_mouse,
    output logic [15:0]                ev_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       overflow_clr,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(STALL_LIMIT) + 1;

    // Counter value on the edge where the stall count reaches STALL_LIMIT-1.
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 2);
    localparam logic [LVL_W-1:0]   LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_CLR = 2'd2,
        ST_STALL    = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            sat_inc = value;
        end else begin
            sat_inc = value + CNT_W'(1);
        end
    endfunction

    logic [1:0]         rst_sync_r;
    logic               rst_n_s;
    state_t             state_r;
    logic [STALL_W-1:0] stall_cnt_r;
    logic [16:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [LVL_W-1:0]   level_nxt_s;
    logic               valid_r;
    logic               retrieved_r;
    logic               overflow_r;
    logic [CNT_W-1:0]   drop_cnt_r;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;
    logic [16:0]        head_s;

    // Reset synchroniser: asserts asynchronously, releases after two clk edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    assign full_s = (level_r == LVL_FULL);
    assign push_s = (state_r == ST_IDLE) && kb_data_ready && !full_s;
    assign pop_s  = valid_r && ev_ready;
    assign drop_s = (state_r == ST_STALL) && full_s && kb_data_ready && (stall_cnt_r == STALL_LAST);

    // Next occupancy from push/pop events; flush overrides everything.
    always_comb begin
        level_nxt_s = level_r;
        if (flush) begin
            level_nxt_s = {LVL_W{1'b0}};
        end else if (push_s && !pop_s) begin
            level_nxt_s = level_r + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            level_nxt_s = level_r - LVL_W'(1);
        end else begin
            level_nxt_s = level_r;
        end
    end

    // Occupancy, pointers and the registered valid flag.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            level_r  <= {LVL_W{1'b0}};
            valid_r  <= 1'b0;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            level_r  <= {LVL_W{1'b0}};
            valid_r  <= 1'b0;
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            level_r <= level_nxt_s;
            valid_r <= (level_nxt_s != {LVL_W{1'b0}});
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
        end
    end

    // Entry storage; a push coinciding with flush is discarded.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 17'd0;
            end
        end else if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= {kb_is_mouse, kb_data};
        end
    end

    // Fetch FSM: accept, acknowledge, wait for upstream to clear, or stall on full.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r     <= ST_IDLE;
            stall_cnt_r <= {STALL_W{1'b0}};
            retrieved_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_cnt_r <= {STALL_W{1'b0}};
                    if (kb_data_ready && !full_s) begin
                        retrieved_r <= 1'b1;
                        state_r     <= ST_ACK;
                    end else if (kb_data_ready) begin
                        retrieved_r <= 1'b0;
                        state_r     <= ST_STALL;
                    end else begin
                        retrieved_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    retrieved_r <= 1'b0;
                    stall_cnt_r <= {STALL_W{1'b0}};
                    state_r     <= ST_WAIT_CLR;
                end
                ST_WAIT_CLR: begin
                    retrieved_r <= 1'b0;
                    // A ready that persists two cycles is taken as a fresh word.
                    if (!kb_data_ready || (stall_cnt_r == STALL_W'(1))) begin
                        stall_cnt_r <= {STALL_W{1'b0}};
                        state_r     <= ST_IDLE;
                    end else begin
                        stall_cnt_r <= stall_cnt_r + STALL_W'(1);
                        state_r     <= ST_WAIT_CLR;
                    end
                end
                ST_STALL: begin
                    if (!full_s || !kb_data_ready) begin
                        retrieved_r <= 1'b0;
                        stall_cnt_r <= {STALL_W{1'b0}};
                        state_r     <= ST_IDLE;
                    end else if (drop_s) begin
                        retrieved_r <= 1'b1;
                        stall_cnt_r <= {STALL_W{1'b0}};
                        state_r     <= ST_ACK;
                    end else begin
                        retrieved_r <= 1'b0;
                        stall_cnt_r <= stall_cnt_r + STALL_W'(1);
                        state_r     <= ST_STALL;
                    end
                end
                default: begin
                    retrieved_r <= 1'b0;
                    stall_cnt_r <= {STALL_W{1'b0}};
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    // Loss bookkeeping; a drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            drop_cnt_r <= overflow_clr ? CNT_W'(1) : sat_inc(drop_cnt_r);
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign head_s            = valid_r ? mem_r[rd_ptr_r] : 17'd0;
    assign ev_valid          = valid_r;
    assign ev_is_mouse       = head_s[16];
    assign ev_data           = head_s[15:0];
    assign kb_data_retrieved = retrieved_r;
    assign level             = level_r;
    assign overflow          = overflow_r;
    assign drop_count        = drop_cnt_r;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Randomised self-checking bench for kbd_event_fifo against a queue-based reference model.
module tb_kbd_event_fifo;

    localparam int DEPTH       = 8;
    localparam int STALL_LIMIT = 16;
    localparam int CNT_W       = 8;
    localparam int CNT_SAT     = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        kb_data_ready = 1'b0;
    logic        kb_is_mouse = 1'b0;
    logic [15:0] kb_data = 16'd0;
    logic        kb_data_retrieved;
    logic        ev_valid;
    logic        ev_ready = 1'b0;
    logic        ev_is_mouse;
    logic [15:0] ev_data;
    logic        flush = 1'b0;
    logic [3:0]  level;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    logic [7:0]  drop_count;

    kbd_event_fifo #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .kb_data_ready(kb_data_ready), .kb_is_mouse(kb_is_mouse), .kb_data(kb_data),
        .kb_data_retrieved(kb_data_retrieved),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_is_mouse(ev_is_mouse), .ev_data(ev_data),
        .flush(flush), .level(level), .overflow(overflow), .overflow_clr(overflow_clr),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: queue of {is_mouse, data}, sticky overflow, saturating drop count.
    logic [16:0] q[$];
    int m_ovf = 0;
    int m_drops = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        logic [16:0] head;
        head = (q.size() > 0) ? q[0] : 17'd0;
        check({tag, ".level"}, 32'(level), 32'(q.size()));
        check({tag, ".valid"}, 32'(ev_valid), 32'(q.size() > 0));
        check({tag, ".data"}, 32'(ev_data), 32'(head[15:0]));
        check({tag, ".mouse"}, 32'(ev_is_mouse), 32'(head[16]));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
    endtask

    // Present one word, optionally pop/clear at a given observation, follow the upstream handshake.
    task automatic send_word(input logic m, input logic [15:0] d, input int pop_at,
                             input int clr_at, input bit flush_first, output int lat);
        int obs;
        bit got;
        obs = 0;
        got = 1'b0;
        lat = -1;
        kb_is_mouse = m;
        kb_data = d;
        kb_data_ready = 1'b1;
        if (flush_first) flush = 1'b1;
        while (!got && obs < STALL_LIMIT + 40) begin
            @(negedge clk);
            obs++;
            if (flush_first && obs == 1) begin
                flush = 1'b0;
                q.delete();
            end
            if (pop_at != 0 && obs == pop_at + 1) begin
                ev_ready = 1'b0;
                if (q.size() > 0) void'(q.pop_front());
            end
            if (clr_at != 0 && obs == clr_at + 1) begin
                overflow_clr = 1'b0;
                m_ovf = 0;
                m_drops = 0;
            end
            if (kb_data_retrieved) begin
                got = 1'b1;
            end else begin
                if (pop_at != 0 && obs == pop_at) ev_ready = 1'b1;
                if (clr_at != 0 && obs == clr_at) overflow_clr = 1'b1;
            end
        end
        if (!got) begin
            check("strobe_timeout", 32'd0, 32'd1);
            kb_data_ready = 1'b0;
            ev_ready = 1'b0;
            overflow_clr = 1'b0;
            @(negedge clk);
        end else begin
            lat = obs;
            if (!flush_first) begin
                if (q.size() < DEPTH) begin
                    q.push_back({m, d});
                end else begin
                    m_ovf = 1;
                    if (m_drops < CNT_SAT) m_drops++;
                end
            end
            check_state("after_strobe");
            @(negedge clk);
            check("strobe_width", 32'(kb_data_retrieved), 32'd0);
            kb_data_ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain(input int n);
        check_state("drain_start");
        ev_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (q.size() > 0) void'(q.pop_front());
            check_state("drain");
        end
        ev_ready = 1'b0;
    endtask

    task automatic send_auto(input logic m, input logic [15:0] d);
        int lat;
        int exp_lat;
        exp_lat = (q.size() >= DEPTH) ? STALL_LIMIT : 1;
        send_word(m, d, 0, 0, 1'b0, lat);
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic pulse_clr();
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        m_ovf = 0;
        m_drops = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // Reset values
        repeat (3) @(negedge clk);
        check("reset.retrieved", 32'(kb_data_retrieved), 32'd0);
        check_state("reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single accept: strobe one clk after ready, head visible
        send_auto(1'b0, 16'h2A15);
        drain(1);

        // Three words in order, then drain with one extra ready-while-empty cycle
        send_auto(1'b1, 16'h0102);
        send_auto(1'b0, 16'h0304);
        send_auto(1'b1, 16'h0506);
        drain(4);

        // Fill, then a ninth word is dropped after the stall limit
        for (int i = 0; i < DEPTH; i++) send_auto(1'($urandom), 16'($urandom));
        send_auto(1'b1, 16'hBEEF);
        check_state("after_drop");

        // Pop during stall: FIFO frees, FSM returns to IDLE, word written one edge later
        pulse_clr();
        send_word(1'b0, 16'hCAFE, 5, 0, 1'b0, lat);
        check("stall_pop.latency", 32'(lat), 32'd8);
        check_state("stall_pop");

        // 300 forced drops: count saturates
        for (int i = 0; i < 300; i++) send_word(1'($urandom), 16'($urandom), 0, 0, 1'b0, lat);
        check("sat.drops", 32'(drop_count), 32'(CNT_SAT));
        check("sat.ovf", 32'(overflow), 32'd1);
        pulse_clr();
        check_state("after_clr");
        // Clear coincident with a drop: drop wins
        send_word(1'b0, 16'h1111, 0, STALL_LIMIT - 1, 1'b0, lat);
        check("clr_drop.latency", 32'(lat), 32'(STALL_LIMIT));
        check("clr_drop.drops", 32'(drop_count), 32'd1);
        check("clr_drop.ovf", 32'(overflow), 32'd1);

        // Flush coincident with accept: word discarded, strobe still issued
        drain(3);
        send_word(1'b1, 16'h7777, 0, 0, 1'b1, lat);
        check("flush_push.latency", 32'(lat), 32'd1);
        check_state("flush_push");

        // Randomised mix of pushes, pop bursts and flushes
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0, 1: send_auto(1'($urandom), 16'($urandom));
                2: begin
                    for (int c = 0; c < int'($urandom_range(1, 6)); c++) begin
                        ev_ready = 1'($urandom);
                        @(negedge clk);
                        if (ev_ready && q.size() > 0) void'(q.pop_front());
                        check_state("rand_pop");
                    end
                    ev_ready = 1'b0;
                end
                default: begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                    q.delete();
                    check_state("rand_flush");
                end
            endcase
        end

        // Asynchronous reset in ACK with five entries
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        q.delete();
        for (int i = 0; i < 4; i++) send_auto(1'($urandom), 16'($urandom));
        kb_is_mouse = 1'b1;
        kb_data = 16'h5A5A;
        kb_data_ready = 1'b1;
        @(negedge clk);
        check("mid_ack.retrieved", 32'(kb_data_retrieved), 32'd1);
        check("mid_ack.level", 32'(level), 32'd5);
        #1 reset_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 0;
        m_drops = 0;
        check("async_rst.retrieved", 32'(kb_data_retrieved), 32'd0);
        check_state("async_rst");
        kb_data_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send_auto(1'b0, 16'h4242);
        check("post_rst.level", 32'(level), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_event_fifo.md
Name: kbd_event_fifo

Overview:
- Sits directly downstream of the keyboard/mouse serial receiver, on the monitor clock.
- Collects each decoded 16-bit keyboard or mouse word and returns the one-cycle "retrieved" strobe.
- Buffers words with their source flag in a small FIFO and presents them to the host-side register interface through a valid/ready handshake.
- If the FIFO stays full too long, it drops the upstream word so the receiver keeps polling, and records the loss.

Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- STALL_LIMIT, 4096: clk cycles data_ready may stay high while FIFO is full before the word is dropped; must be >= 2.
- CNT_W, 8: width of drop_count.

Ports:
- clk  in  1  monitor clock.
- reset_n  in  1  asynchronous active-low reset.
- kb_data_ready  in  1  upstream has a word.
- kb_is_mouse  in  1  upstream word is mouse data (0 = keyboard).
- kb_data  in  16  upstream word.
- kb_data_retrieved  out  1  one-cycle acknowledge to upstream.
- ev_valid  out  1  head entry valid.
- ev_ready  in  1  host consumes head entry.
- ev_is_mouse  out  1  head entry source flag.
- ev_data  out  16  head entry word.
- flush  in  1  synchronous clear of FIFO contents.
- level  out  clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set on any drop.
- overflow_clr  in  1  clears overflow and drop_count.
- drop_count  out  CNT_W  number of dropped words; saturates.

Behaviour:
- Reset (async, reset_n=0) values:
  - kb_data_retrieved=0, ev_valid=0, ev_is_mouse=0, ev_data=0.
  - level=0, overflow=0, drop_count=0.
  - FSM=IDLE, stall counter=0, pointers=0.
- Reset deassertion is synchronised internally; the first active edge follows two clk edges with reset_n high.
- Upstream latency: data_ready falls one clk after the retrieved strobe. The fetch FSM therefore never re-samples a word before it has cleared.
- Fetch FSM states:
  - IDLE:
    - If kb_data_ready and FIFO not full: write {kb_is_mouse, kb_data} at the tail, assert kb_data_retrieved for exactly one cycle, go to ACK.
    - If kb_data_ready and FIFO full: go to STALL and clear the stall counter.
  - ACK: kb_data_retrieved=0; go to WAIT_CLR.
  - WAIT_CLR: go to IDLE when kb_data_ready=0. If it is still high after 2 cycles, treat it as a new word and go to IDLE anyway.
  - STALL: the counter increments each cycle.
    - If the FIFO becomes not full: go to IDLE with no write this cycle. The write happens next cycle.
    - If kb_data_ready drops: go to IDLE.
    - If the counter reaches STALL_LIMIT-1: pulse kb_data_retrieved with no write, set overflow, increment drop_count (saturate at all-ones), go to ACK.
- FIFO:
  - First-word-fall-through: ev_valid=1 whenever level>0, and ev_data/ev_is_mouse show the head entry combinationally from registered storage.
  - A pop occurs on ev_valid && ev_ready.
  - ev_ready while empty is ignored.
  - A push occurs only in IDLE on accept.
  - Simultaneous push and pop when full is impossible because accept requires not full. Push and pop in the same cycle at any other level leave level unchanged.
  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. level is computed from push/pop, never from the pointers alone.
- flush:
  - Pointers and level go to 0 next edge, and ev_valid falls.
  - A push in the same cycle is discarded, but its retrieved strobe is still issued, so the word counts as consumed.
  - The FSM state is not altered, and overflow/drop_count are unaffected.
- overflow_clr: clears overflow and drop_count next edge. If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- kb_data and kb_is_mouse are sampled only in the IDLE accept cycle. Upstream holds them stable while data_ready=1.

Test Plan:
- Reset then kb_data_ready=1, kb_data=16'h2A15, kb_is_mouse=0:
  - kb_data_retrieved pulses exactly 1 cycle after 1 clk.
  - ev_valid=1 and ev_data=16'h2A15 the cycle after the write.
  - level=1.
- Push 3 words (mouse 16'h0102, kbd 16'h0304, mouse 16'h0506) with ev_ready=0, then hold ev_ready=1:
  - Pops occur in order with the correct flags.
  - level counts 3,2,1,0 and ev_valid falls after the third pop.
- Fill to DEPTH=8, hold a 9th word with STALL_LIMIT=16:
  - No strobe for 15 cycles, then one strobe.
  - overflow=1, drop_count=1, level stays 8 and contents are unchanged.
- Same as the previous case, but assert ev_ready for 1 cycle at stall cycle 5:
  - The 9th word is written. No drop and no overflow; level returns to 8.
- Run 300 forced drops with CNT_W=8:
  - drop_count saturates at 255.
  - overflow_clr gives 0/0. overflow_clr coincident with a drop gives overflow=1, drop_count=1.
- reset_n low mid-ACK with level=5:
  - All outputs return to reset values asynchronously.
  - After release, a new word is accepted normally and level=1.
